serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the signed-overflow rule applied to the captured operand sign bits.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of a - b: operand signs differ and the result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: difference and borrow-out for a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures a, b, borrow_in on start and resolves one bit per
// cycle LSB first; results appear together with a one-cycle done pulse.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-2:0] res_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             d_s;
    logic             bout_s;
    logic             load_s;
    logic             step_s;
    logic             last_bit_s;

    full_subtractor u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bout_s)
    );

    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));
    // New bit enters at the top so the final shift leaves the full result aligned.
    assign res_nxt_s  = {d_s, res_r};

    // Next-state decode and datapath enables.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != IDLE);
            done    <= (state_nxt_s == DONE);
        end
    end

    // Operand/result shifting, running borrow, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_r    <= {(WIDTH-1){1'b0}};
            br_r     <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            diff     <= {WIDTH{1'b0}};
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (load_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            br_r    <= borrow_in;
            cnt_r   <= {CW{1'b0}};
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
        end else if (step_s) begin
            a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_r  <= res_nxt_s[WIDTH-1:1];
            br_r   <= bout_s;
            if (last_bit_s) begin
                diff     <= res_nxt_s;
                borrow   <= bout_s;
                overflow <= sub_overflow(a_msb_r, b_msb_r, d_s);
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit directed vectors with literal expectations and a
// 16-bit back-to-back random run, both tracked by an arithmetic reference model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8, bi8, busy8, done8, br8, ov8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bi16, busy16, done16, br16, ov16;
    logic [15:0] a16, b16, diff16;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(br8), .overflow(ov8));

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .borrow_in(bi16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(br16), .overflow(ov16));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ndone8 = 0;
    int ndone16 = 0;
    int last16 = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void ref_sub(input int w, input int ra, input int rb, input int rbi,
                                    output logic [15:0] d, output logic br, output logic ov);
        int r, sa, sb, half;
        half = 1 << (w - 1);
        r    = ra - rb - rbi;
        d    = 16'(r & ((1 << w) - 1));
        br   = (r < 0);
        sa   = (ra >= half) ? ra - 2 * half : ra;
        sb   = (rb >= half) ? rb - 2 * half : rb;
        r    = sa - sb - rbi;
        ov   = (r < -half) || (r > half - 1);
    endfunction

    // Model state per channel (0 = 8-bit DUT, 1 = 16-bit DUT); m_cnt = cycles left busy.
    int          wid[2] = '{8, 16};
    int          m_cnt[2];
    int          m_a[2], m_b[2], m_bi[2];
    logic [15:0] m_diff[2];
    logic        m_br[2], m_ov[2];
    logic        mdl_s;
    int          mdl_a, mdl_b, mdl_bi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_cnt[ch] = 0; m_diff[ch] = 16'h0; m_br[ch] = 1'b0; m_ov[ch] = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                mdl_s  = (ch == 0) ? start8 : start16;
                mdl_a  = (ch == 0) ? int'(a8) : int'(a16);
                mdl_b  = (ch == 0) ? int'(b8) : int'(b16);
                mdl_bi = (ch == 0) ? int'(bi8) : int'(bi16);
                if (m_cnt[ch] == 0) begin
                    if (mdl_s) begin
                        m_a[ch] = mdl_a; m_b[ch] = mdl_b; m_bi[ch] = mdl_bi;
                        m_cnt[ch] = wid[ch] + 1;
                    end
                end else begin
                    m_cnt[ch]--;
                    if (m_cnt[ch] == 1)
                        ref_sub(wid[ch], m_a[ch], m_b[ch], m_bi[ch], m_diff[ch], m_br[ch], m_ov[ch]);
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus done counting and 16-bit period.
    always @(negedge clk) begin
        cyc++;
        chk("busy8", busy8, m_cnt[0] > 0);
        chk("done8", done8, m_cnt[0] == 1);
        chk("diff8", diff8, m_diff[0][7:0]);
        chk("borrow8", br8, m_br[0]);
        chk("ovf8", ov8, m_ov[0]);
        chk("busy16", busy16, m_cnt[1] > 0);
        chk("done16", done16, m_cnt[1] == 1);
        chk("diff16", diff16, m_diff[1]);
        chk("borrow16", br16, m_br[1]);
        chk("ovf16", ov16, m_ov[1]);
        if (done8) ndone8++;
        if (done16) begin
            ndone16++;
            if (last16 >= 0) chk("period16", cyc - last16, 18);
            last16 = cyc;
        end
    end

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                       input logic [7:0] ed, input logic eb, input logic eo,
                       input bit now, input string nm);
        int lat;
        if (!now) @(negedge clk);
        a8 = ta; b8 = tb; bi8 = tbi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 9);
        chk({nm, "_diff"}, diff8, ed);
        chk({nm, "_borrow"}, br8, eb);
        chk({nm, "_ovf"}, ov8, eo);
        @(posedge clk); #1;
    endtask

    int d0;
    int guard;

    initial begin
        start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; bi8 = 1'b0;
        start16 = 1'b0; a16 = 16'h0; b16 = 16'h0; bi16 = 1'b0;
        #12;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_diff16", diff16, 0);

        // First start presented together with reset release.
        @(negedge clk); rst_n = 1'b1;
        op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1, "v030");
        op8(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, "v031");
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "v032");
        op8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, "zero_m_ff_bi");
        op8(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, "max_m_min");

        // Start during RUN cycle 3 with different operands must be ignored.
        d0 = ndone8;
        @(negedge clk); a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h01; bi8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("v033_diff", diff8, 8'h37);
        chk("v033_done_pulses", ndone8 - d0, 1);
        chk("v033_idle", busy8, 0);

        // Reset in RUN cycle 4 aborts; the next operation starts on the first edge after release.
        d0 = ndone8;
        @(negedge clk); a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("v034_rst_busy", busy8, 0);
        chk("v034_rst_diff", diff8, 0);
        repeat (3) @(negedge clk);
        chk("v034_no_done", ndone8 - d0, 0);
        rst_n = 1'b1;
        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, "v034");
        repeat (12) @(posedge clk);
        #1;
        chk("v034_done_pulses", ndone8 - d0, 1);

        // 16-bit back-to-back random run with start held high.
        @(negedge clk);
        a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom_range(0, 1));
        start16 = 1'b1;
        guard = 0;
        while (ndone16 < 1000 && guard < 20000) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom_range(0, 1));
            guard++;
        end
        start16 = 1'b0;
        chk("v035_ops", ndone16 >= 1000, 1);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
